uart_tx_sched: RTL and testbench

Multi-requester scheduler sitting in front of the UART transmitter. It arbitrates byte-send requests from up to NREQ on-chip sources and captures the winning byte. It drives the transmitter's `p_data` / `data_valid` / `par_en` / `par_typ` inputs and tracks the transmitter's `busy` output to sequence back-to-back frames. It also enforces a per-grant burst limit and detects a transmitter that never starts.

---
 rtl/uart_tx_sched_if.sv | 31 +++
 rtl/uart_tx_sched.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Request/transmitter bundle for uart_tx_sched: requester handshake, captured frame
// and transmitter control. The scheduler takes the slave view, its environment the master view.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
) ();
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic              cfg_par_en;
    logic              cfg_par_typ;
    logic [NREQ-1:0]   req_ack;
    logic [7:0]        p_data;
    logic              data_valid;
    logic              par_en;
    logic              par_typ;
    logic              busy;
    logic [GW-1:0]     grant_id;
    logic              tx_done;
    logic              timeout_err;

    modport slave (
        input  req, req_data, cfg_par_en, cfg_par_typ, busy,
        output req_ack, p_data, data_valid, par_en, par_typ, grant_id, tx_done, timeout_err
    );

    modport master (
        output req, req_data, cfg_par_en, cfg_par_typ, busy,
        input  req_ack, p_data, data_valid, par_en, par_typ, grant_id, tx_done, timeout_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Multi-requester byte scheduler in front of a UART transmitter: arbitration, burst limit
// and busy-start watchdog. Define UART_TX_SCHED_RR_EN for round-robin, else fixed priority.
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic           clck,
    input  logic           rst,
    uart_tx_sched_if.slave sched
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      p_data_q, p_data_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    logic [NREQ-1:0] ack_vec;
    logic            launch;
    logic            done_pulse;
    logic            to_pulse;

    logic [7:0]      req_byte [NREQ];
    logic [NREQ-1:0] req_rot;
    logic            arb_any;
    logic [GW-1:0]   arb_off;
    logic [GW-1:0]   arb_win;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_byte
            assign req_byte[gi] = sched.req_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_TX_SCHED_RR_EN
    localparam logic [GW:0] NREQ_W = (GW+1)'(NREQ);
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_next;
    logic [GW:0]   arb_sum;

    // Rotate so bit 0 is the pointer position; the winner is pointer + offset, wrapped.
    assign req_rot    = NREQ'({sched.req, sched.req} >> ptr_q);
    assign arb_sum    = {1'b0, ptr_q} + {1'b0, arb_off};
    assign arb_win    = (arb_sum >= NREQ_W) ? GW'(arb_sum - NREQ_W) : arb_sum[GW-1:0];
    assign grant_next = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + GW'(1);
`else
    assign req_rot = sched.req;
    assign arb_win = arb_off;
`endif

    // Lowest set bit of the (rotated) request vector.
    always_comb begin
        arb_any = 1'b0;
        arb_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                arb_any = 1'b1;
                arb_off = GW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        p_data_d    = p_data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        to_cnt_d    = to_cnt_q;
        ack_vec     = '0;
        launch      = 1'b0;
        done_pulse  = 1'b0;
        to_pulse    = 1'b0;
`ifdef UART_TX_SCHED_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!sched.busy && arb_any) begin
                    ack_vec[arb_win] = 1'b1;
                    p_data_d         = req_byte[arb_win];
                    par_en_d         = sched.cfg_par_en;
                    par_typ_d        = sched.cfg_par_typ;
                    grant_id_d       = arb_win;
                    burst_cnt_d      = '0;
                    state_d          = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                launch   = 1'b1;
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (sched.busy) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    to_pulse = 1'b1;
`ifdef UART_TX_SCHED_RR_EN
                    ptr_d    = grant_next;
`endif
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!sched.busy) begin
                    done_pulse = 1'b1;
                    // Continue the burst straight into LAUNCH, no IDLE bubble.
                    if (sched.req[grant_id_q] && (burst_cnt_q < BURST_LAST)) begin
                        ack_vec[grant_id_q] = 1'b1;
                        p_data_d            = req_byte[grant_id_q];
                        par_en_d            = sched.cfg_par_en;
                        par_typ_d           = sched.cfg_par_typ;
                        burst_cnt_d         = burst_cnt_q + BW'(1);
                        state_d             = S_LAUNCH;
                    end else begin
`ifdef UART_TX_SCHED_RR_EN
                        ptr_d   = grant_next;
`endif
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            state_q     <= S_IDLE;
            p_data_q    <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            to_cnt_q    <= '0;
`ifdef UART_TX_SCHED_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            p_data_q    <= p_data_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            to_cnt_q    <= to_cnt_d;
`ifdef UART_TX_SCHED_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // Strobes are suppressed while reset is held so an abandoned frame reports nothing.
    assign sched.req_ack     = rst ? '0 : ack_vec;
    assign sched.data_valid  = launch & ~rst;
    assign sched.tx_done     = done_pulse & ~rst;
    assign sched.timeout_err = to_pulse & ~rst;
    assign sched.p_data      = p_data_q;
    assign sched.par_en      = par_en_q;
    assign sched.par_typ     = par_typ_q;
    assign sched.grant_id    = grant_id_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: single frame, contention, burst, timeout, reset, parity hold.
// A simple transmitter model raises busy the cycle after data_valid for busy_len cycles.
module tb_uart_tx_sched;
    localparam int NREQ         = 4;
    localparam int MAX_BURST    = 4;
    localparam int BUSY_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NREQ(NREQ)) bus ();

    uart_tx_sched #(
        .NREQ(NREQ),
        .MAX_BURST(MAX_BURST),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) u_dut (
        .clck (clk),
        .rst  (rst),
        .sched(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model
    logic busy_on;
    int   busy_len;
    int   busy_cnt;
    logic dv_last;
    initial begin
        bus.busy = 1'b0;
        busy_cnt = 0;
        dv_last  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy_on) begin
                bus.busy = 1'b0;
                busy_cnt = 0;
            end else if (dv_last) begin
                bus.busy = 1'b1;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bus.busy = 1'b0;
            end
            dv_last = bus.data_valid;
        end
    end

    // Event log, one line printed per launched or aborted frame
    int         cyc = 0;
    int         ack_src_q[$];
    int         ack_cyc_q[$];
    logic [7:0] dv_data_q[$];
    int         n_txd, txd_cyc, n_to, to_cyc;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #4;
            if (bus.req_ack != '0) begin
                check("ack_onehot", 32'($countones(bus.req_ack)), 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_ack[i]) begin
                        ack_src_q.push_back(i);
                        ack_cyc_q.push_back(cyc);
                    end
                end
            end
            if (bus.data_valid) begin
                dv_data_q.push_back(bus.p_data);
                $display("cyc %0d launch src=%0d data=%02h par_en=%b par_typ=%b",
                         cyc, bus.grant_id, bus.p_data, bus.par_en, bus.par_typ);
            end
            if (bus.tx_done) begin
                n_txd++;
                txd_cyc = cyc;
            end
            if (bus.timeout_err) begin
                n_to++;
                to_cyc = cyc;
                $display("cyc %0d timeout src=%0d", cyc, bus.grant_id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic clear_log();
        ack_src_q.delete();
        ack_cyc_q.delete();
        dv_data_q.delete();
        n_txd = 0;
        n_to  = 0;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.req         = '0;
        bus.cfg_par_en  = 1'b0;
        bus.cfg_par_typ = 1'b0;
        busy_on         = 1'b0;
        repeat (3) tick();
        rst     = 1'b0;
        busy_on = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    int t0;
    int exp_src;
    int gap;

    initial begin
        rst             = 1'b1;
        bus.req         = '0;
        bus.req_data    = '0;
        bus.cfg_par_en  = 1'b0;
        bus.cfg_par_typ = 1'b0;
        busy_on         = 1'b0;
        busy_len        = 3;
        clear_log();

        // Reset values
        do_reset();
        mid();
        check("rst_p_data",   32'(bus.p_data), 32'h0);
        check("rst_dv",       32'(bus.data_valid), 32'h0);
        check("rst_par",      32'({bus.par_en, bus.par_typ}), 32'h0);
        check("rst_ack",      32'(bus.req_ack), 32'h0);
        check("rst_grant",    32'(bus.grant_id), 32'h0);
        check("rst_strobes",  32'({bus.tx_done, bus.timeout_err}), 32'h0);

        // Single request
        tick();
        busy_len = 11;
        clear_log();
        t0 = cyc;
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'hA5;
        mid();
        check("s_ack", 32'(bus.req_ack), 32'h1);
        tick();
        bus.req = '0;
        mid();
        check("s_dv",     32'(bus.data_valid), 32'h1);
        check("s_p_data", 32'(bus.p_data), 32'hA5);
        check("s_grant",  32'(bus.grant_id), 32'h0);
        repeat (20) tick();
        check("s_ndone",    32'(n_txd), 32'd1);
        check("s_done_cyc", 32'(txd_cyc - t0), 32'd13);
        check("s_nacks",    32'(ack_src_q.size()), 32'd1);

        // Contention, all four requests held
        do_reset();
        busy_len = 2;
        clear_log();
        bus.req      = 4'b1111;
        bus.req_data = 32'h44332211;
        repeat (45) tick();
        bus.req = '0;
        repeat (15) tick();
        check("c_nacks_ge8", 32'(ack_src_q.size() >= 8), 32'd1);
        if (ack_src_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
`ifdef UART_TX_SCHED_RR_EN
                exp_src = (i < 4) ? 0 : 1;
`else
                exp_src = 0;
`endif
                check($sformatf("c_src%0d", i), 32'(ack_src_q[i]), 32'(exp_src));
            end
            check("c_gap_burst",  32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd4);
            check("c_gap_rearb",  32'(ack_cyc_q[4] - ack_cyc_q[3]), 32'd5);
`ifdef UART_TX_SCHED_RR_EN
            check("c_data4", 32'(dv_data_q[4]), 32'h22);
`else
            check("c_data4", 32'(dv_data_q[4]), 32'h11);
`endif
        end

        // Burst of six bytes from source 2
        do_reset();
        busy_len = 2;
        clear_log();
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'h10;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (ack_src_q.size() >= 6) bus.req = '0;
            else bus.req_data[23:16] = 8'h10 + 8'(ack_src_q.size());
        end
        check("b_nacks", 32'(ack_src_q.size()), 32'd6);
        check("b_ndone", 32'(n_txd), 32'd6);
        if (ack_src_q.size() == 6 && dv_data_q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("b_src%0d", k), 32'(ack_src_q[k]), 32'd2);
                check($sformatf("b_data%0d", k), 32'(dv_data_q[k]), 32'(8'h10 + k));
            end
            for (int k = 1; k < 6; k++) begin
                gap = (k == 4) ? 5 : 4;
                check($sformatf("b_gap%0d", k), 32'(ack_cyc_q[k] - ack_cyc_q[k-1]), 32'(gap));
            end
        end

        // Timeout: transmitter never raises busy
        do_reset();
        busy_on = 1'b0;
        clear_log();
        t0 = cyc;
        bus.req = 4'b0010;
        bus.req_data[15:8] = 8'h77;
        tick();
        bus.req = '0;
        while (cyc < t0 + 17) tick();
        check("t_nto",    32'(n_to), 32'd1);
        check("t_to_cyc", 32'(to_cyc - t0), 32'd16);
        check("t_ndone",  32'(n_txd), 32'd0);
        busy_on  = 1'b1;
        busy_len = 2;
        bus.req  = 4'b1001;
        mid();
`ifdef UART_TX_SCHED_RR_EN
        check("t_next_ack", 32'(bus.req_ack), 32'h8);
`else
        check("t_next_ack", 32'(bus.req_ack), 32'h1);
`endif
        tick();
        bus.req = '0;
        repeat (10) tick();

        // Reset while waiting for the frame to finish
        do_reset();
        busy_len = 11;
        clear_log();
        t0 = cyc;
        bus.req = 4'b1000;
        bus.req_data[31:24] = 8'h99;
        tick();
        bus.req = '0;
        while (cyc < t0 + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1001;
        mid();
        check("r_p_data", 32'(bus.p_data), 32'h0);
        check("r_grant",  32'(bus.grant_id), 32'h0);
        check("r_dv",     32'(bus.data_valid), 32'h0);
        check("r_ack_busy", 32'(bus.req_ack), 32'h0);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ack_src_q.size() >= 2) bus.req = '0;
        end
        check("r_nacks", 32'(ack_src_q.size()), 32'd2);
        if (ack_src_q.size() >= 2) begin
            check("r_src",     32'(ack_src_q[1]), 32'd0);
            check("r_ack_cyc", 32'(ack_cyc_q[1] - t0), 32'd13);
        end
        check("r_ndone",    32'(n_txd), 32'd1);
        check("r_done_cyc", 32'(txd_cyc - t0), 32'd26);

        // Parity configuration held across a frame
        do_reset();
        busy_len = 6;
        clear_log();
        t0 = cyc;
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'h3C;
        bus.cfg_par_en  = 1'b1;
        bus.cfg_par_typ = 1'b1;
        tick();
        bus.req = '0;
        bus.cfg_par_en  = 1'b0;
        bus.cfg_par_typ = 1'b0;
        mid();
        check("p_launch_par", 32'({bus.par_en, bus.par_typ}), 32'h3);
        while (cyc < t0 + 4) tick();
        bus.cfg_par_en = 1'b1;
        mid();
        check("p_hold_par",    32'({bus.par_en, bus.par_typ}), 32'h3);
        check("p_hold_p_data", 32'(bus.p_data), 32'h3C);
        while (cyc < t0 + 10) tick();
        check("p_idle_par", 32'({bus.par_en, bus.par_typ}), 32'h3);
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'hC3;
        bus.cfg_par_en  = 1'b0;
        bus.cfg_par_typ = 1'b1;
        mid();
        check("p_ack2", 32'(bus.req_ack), 32'h4);
        tick();
        bus.req = '0;
        bus.cfg_par_typ = 1'b0;
        mid();
        check("p_new_par",    32'({bus.par_en, bus.par_typ}), 32'h1);
        check("p_new_p_data", 32'(bus.p_data), 32'hC3);
        repeat (15) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
